// File: rtl/snake_pkg.sv
// snake_pkg
//   Shared definitions for the snake game: screen-state encoding, snake
//   direction encoding and small helpers for direction handling. Imported
//   by the game controller and by the snake movement-and-render block.
package snake_pkg;

  // Screen states driven on game_state.
  typedef enum logic [2:0] {
    STATE_IDLE            = 3'd0,
    STATE_START_INTERFACE = 3'd1,
    STATE_CHOOSE_LEVEL    = 3'd2,
    STATE_PLAY            = 3'd3,
    STATE_PAUSE           = 3'd4,
    STATE_WIN_INTERFACE   = 3'd5
  } game_state_e;

  // Snake heading driven on dir_state.
  typedef enum logic [1:0] {
    UP    = 2'd0,
    LEFT  = 2'd1,
    DOWN  = 2'd2,
    RIGHT = 2'd3
  } dir_e;

  // Result of resolving simultaneous direction key pulses.
  typedef struct packed {
    logic valid;
    dir_e dir;
  } dir_key_t;

  // Encoding puts opposites two apart, so flipping bit 1 gives the reverse.
  function automatic dir_e opposite_dir(input dir_e d);
    return dir_e'(d ^ 2'b10);
  endfunction

  // Resolve direction key pulses with priority up > left > down > right.
  function automatic dir_key_t pick_dir(input logic up, input logic left,
                                        input logic down, input logic right);
    dir_key_t k;
    k.valid = up | left | down | right;
    if (up)        k.dir = UP;
    else if (left) k.dir = LEFT;
    else if (down) k.dir = DOWN;
    else           k.dir = RIGHT;
    return k;
  endfunction

endpackage

// File: rtl/snake_game_ctrl_bcd2_counter.sv
// bcd2_counter
//   Two-digit BCD counter that saturates at 99.
//   Ports:
//     clk, rst      - clock and synchronous active-high reset (clears to 00)
//     clr           - synchronous clear to 00, wins over inc
//     inc           - add one (ones 9 rolls to 0 and carries into tens)
//     ones, tens    - registered BCD digits
module bcd2_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] ones,
  output logic [3:0] tens
);

  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;

  // Next-count logic: clear first, then increment with decimal carry,
  // holding at 99 instead of wrapping.
  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (clr) begin
      ones_d = 4'd0;
      tens_d = 4'd0;
    end else if (inc && !(ones_q == 4'd9 && tens_q == 4'd9)) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  // Digit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign ones = ones_q;
  assign tens = tens_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl
//   Game controller: sequences the screens, latches the level speed,
//   filters direction changes and keeps the two-digit BCD score that the
//   snake movement-and-render block consumes.
//   Ports:
//     clk, rst                  - clock, synchronous active-high reset
//     key_up/left/down/right    - one-cycle direction key pulses
//     key_enter, key_pause      - one-cycle confirm / pause-toggle pulses
//     key_1, key_2, key_3       - one-cycle level-select pulses
//     target_ate, lost          - level status from the snake block
//     game_state                - current screen (snake_pkg encoding)
//     dir_state                 - snake direction UP=0 LEFT=1 DOWN=2 RIGHT=3
//     mov_speed                 - clk cycles per move step
//     score_count1/0            - BCD tens / ones of the score
//     level                     - selected level 1..3
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter logic [27:0] SPEED_L1  = 28'd20_000_000,
  parameter logic [27:0] SPEED_L2  = 28'd12_000_000,
  parameter logic [27:0] SPEED_L3  = 28'd6_000_000,
  parameter logic [7:0]  WIN_SCORE = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_up,
  input  logic        key_left,
  input  logic        key_down,
  input  logic        key_right,
  input  logic        key_enter,
  input  logic        key_pause,
  input  logic        key_1,
  input  logic        key_2,
  input  logic        key_3,
  input  logic        target_ate,
  input  logic        lost,
  output logic [2:0]  game_state,
  output logic [1:0]  dir_state,
  output logic [27:0] mov_speed,
  output logic [3:0]  score_count0,
  output logic [3:0]  score_count1,
  output logic [1:0]  level
);

  game_state_e state_q, state_d;
  dir_e        dir_q, dir_d;
  logic [27:0] speed_q, speed_d;
  logic [1:0]  level_q, level_d;
  logic        target_ate_d_q, target_ate_d_d;

  logic        score_inc;
  logic        score_clr;
  logic        ate_edge;
  dir_key_t    dir_key;
  logic [3:0]  score_ones;
  logic [3:0]  score_tens;

  // Score lives in its own saturating BCD counter.
  bcd2_counter u_score (
    .clk  (clk),
    .rst  (rst),
    .clr  (score_clr),
    .inc  (score_inc),
    .ones (score_ones),
    .tens (score_tens)
  );

  // Next-state logic for the screen FSM, direction filter, level latch and
  // score control. target_ate is delayed every cycle regardless of state so
  // an edge seen while paused is consumed and never counted afterwards.
  always_comb begin
    state_d        = state_q;
    dir_d          = dir_q;
    speed_d        = speed_q;
    level_d        = level_q;
    target_ate_d_d = target_ate;
    score_inc      = 1'b0;
    score_clr      = 1'b0;
    ate_edge       = target_ate & ~target_ate_d_q;
    dir_key        = pick_dir(key_up, key_left, key_down, key_right);

    case (state_q)
      STATE_START_INTERFACE: begin
        if (key_enter) state_d = STATE_CHOOSE_LEVEL;
      end

      STATE_CHOOSE_LEVEL: begin
        if (key_1) begin
          state_d = STATE_IDLE;
          speed_d = SPEED_L1;
          level_d = 2'd1;
        end else if (key_2) begin
          state_d = STATE_IDLE;
          speed_d = SPEED_L2;
          level_d = 2'd2;
        end else if (key_3) begin
          state_d = STATE_IDLE;
          speed_d = SPEED_L3;
          level_d = 2'd3;
        end
      end

      STATE_IDLE: begin
        // A LEFT start key would reverse onto the initial RIGHT heading.
        if (key_enter || dir_key.valid) begin
          state_d   = STATE_PLAY;
          score_clr = 1'b1;
          if (dir_key.valid && dir_key.dir != LEFT) dir_d = dir_key.dir;
          else                                      dir_d = RIGHT;
        end
      end

      STATE_PLAY: begin
        if (dir_key.valid && dir_key.dir != opposite_dir(dir_q))
          dir_d = dir_key.dir;
        score_inc = ate_edge & ~lost;
        // Win check uses the registered score, one cycle after it lands.
        if (lost)
          state_d = STATE_IDLE;
        else if ({score_tens, score_ones} == WIN_SCORE)
          state_d = STATE_WIN_INTERFACE;
        else if (key_pause)
          state_d = STATE_PAUSE;
      end

      STATE_PAUSE: begin
        if (key_pause) state_d = STATE_PLAY;
      end

      STATE_WIN_INTERFACE: begin
        if (key_enter) state_d = STATE_START_INTERFACE;
      end

      default: begin
        state_d = STATE_START_INTERFACE;
      end
    endcase
  end

  // All controller state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= STATE_START_INTERFACE;
      dir_q          <= RIGHT;
      speed_q        <= SPEED_L1;
      level_q        <= 2'd1;
      target_ate_d_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      dir_q          <= dir_d;
      speed_q        <= speed_d;
      level_q        <= level_d;
      target_ate_d_q <= target_ate_d_d;
    end
  end

  assign game_state   = state_q;
  assign dir_state    = dir_q;
  assign mov_speed    = speed_q;
  assign level        = level_q;
  assign score_count0 = score_ones;
  assign score_count1 = score_tens;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl
//   Bench for snake_game_ctrl: a directed walk through the game flow with
//   literal expectations, followed by randomized key/status traffic. An
//   integer-score screen model tracks the expected outputs every cycle.
module tb_snake_game_ctrl;

  localparam int K_UP    = 1;
  localparam int K_LEFT  = 2;
  localparam int K_DOWN  = 4;
  localparam int K_RIGHT = 8;
  localparam int K_ENTER = 16;
  localparam int K_PAUSE = 32;
  localparam int K_1     = 64;
  localparam int K_2     = 128;
  localparam int K_3     = 256;

  localparam logic [27:0] SP1 = 28'd20_000_000;
  localparam logic [27:0] SP2 = 28'd12_000_000;
  localparam logic [27:0] SP3 = 28'd6_000_000;
  localparam logic [7:0]  WIN = 8'h20;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_up, key_left, key_down, key_right;
  logic        key_enter, key_pause, key_1, key_2, key_3;
  logic        target_ate, lost;
  logic [2:0]  game_state;
  logic [1:0]  dir_state;
  logic [27:0] mov_speed;
  logic [3:0]  score_count0, score_count1;
  logic [1:0]  level;

  int pass_count  = 0;
  int check_count = 0;
  bit check_en    = 1'b0;

  // Reference model: screen number, heading, level and a plain integer score.
  int          m_st;
  int          m_dir;
  int          m_lvl;
  int          m_score;
  logic [27:0] m_speed;
  bit          m_tad;

  snake_game_ctrl #(
    .SPEED_L1  (SP1),
    .SPEED_L2  (SP2),
    .SPEED_L3  (SP3),
    .WIN_SCORE (WIN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_up       (key_up),
    .key_left     (key_left),
    .key_down     (key_down),
    .key_right    (key_right),
    .key_enter    (key_enter),
    .key_pause    (key_pause),
    .key_1        (key_1),
    .key_2        (key_2),
    .key_3        (key_3),
    .target_ate   (target_ate),
    .lost         (lost),
    .game_state   (game_state),
    .dir_state    (dir_state),
    .mov_speed    (mov_speed),
    .score_count0 (score_count0),
    .score_count1 (score_count1),
    .level        (level)
  );

  always #5 clk = ~clk;

  // Model advance on each rising edge from the inputs presented to the DUT.
  always @(posedge clk) begin
    int  dk;
    bit  edge_seen;
    int  win_dec;
    win_dec = int'(WIN[7:4]) * 10 + int'(WIN[3:0]);
    if (rst) begin
      m_st = 1; m_dir = 3; m_speed = SP1; m_lvl = 1; m_score = 0; m_tad = 0;
    end else begin
      edge_seen = target_ate && !m_tad;
      m_tad = target_ate;
      dk = key_up ? 0 : key_left ? 1 : key_down ? 2 : key_right ? 3 : -1;
      case (m_st)
        1: if (key_enter) m_st = 2;
        2: begin
          if (key_1)      begin m_st = 0; m_speed = SP1; m_lvl = 1; end
          else if (key_2) begin m_st = 0; m_speed = SP2; m_lvl = 2; end
          else if (key_3) begin m_st = 0; m_speed = SP3; m_lvl = 3; end
        end
        0: if (key_enter || dk >= 0) begin
          m_st = 3;
          m_score = 0;
          m_dir = (dk >= 0 && dk != 1) ? dk : 3;
        end
        3: begin
          int old_score;
          old_score = m_score;
          if (dk >= 0 && dk != (m_dir + 2) % 4) m_dir = dk;
          if (edge_seen && !lost && m_score < 99) m_score = m_score + 1;
          if (lost)                     m_st = 0;
          else if (old_score == win_dec) m_st = 5;
          else if (key_pause)           m_st = 4;
        end
        4: if (key_pause) m_st = 3;
        5: if (key_enter) m_st = 1;
        default: m_st = 1;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Every-cycle comparison of the DUT against the model, away from the edge.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model_state", 32'(game_state),   32'(m_st));
      checkOutput("model_dir",   32'(dir_state),    32'(m_dir));
      checkOutput("model_speed", 32'(mov_speed),    32'(m_speed));
      checkOutput("model_level", 32'(level),        32'(m_lvl));
      checkOutput("model_ones",  32'(score_count0), 32'(m_score % 10));
      checkOutput("model_tens",  32'(score_count1), 32'(m_score / 10));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic setKeys(input int k);
    key_up    = (k & K_UP)    != 0;
    key_left  = (k & K_LEFT)  != 0;
    key_down  = (k & K_DOWN)  != 0;
    key_right = (k & K_RIGHT) != 0;
    key_enter = (k & K_ENTER) != 0;
    key_pause = (k & K_PAUSE) != 0;
    key_1     = (k & K_1)     != 0;
    key_2     = (k & K_2)     != 0;
    key_3     = (k & K_3)     != 0;
  endtask

  // One-cycle key pulse; outputs are settled on return.
  task automatic applyStimulus(input int k);
    setKeys(k);
    tick();
    setKeys(0);
  endtask

  task automatic feedEdges(input int n);
    for (int i = 0; i < n; i++) begin
      target_ate = 1'b1;
      tick();
      target_ate = 1'b0;
      tick();
    end
  endtask

  task automatic checkScore(input string name, input int tens, input int ones);
    checkOutput({name, "_tens"}, 32'(score_count1), 32'(tens));
    checkOutput({name, "_ones"}, 32'(score_count0), 32'(ones));
  endtask

  initial begin
    rst = 1'b1;
    setKeys(0);
    target_ate = 1'b0;
    lost = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_en = 1'b1;

    // Reset values.
    checkOutput("rst_state", 32'(game_state), 32'd1);
    checkOutput("rst_dir",   32'(dir_state),  32'd3);
    checkOutput("rst_speed", 32'(mov_speed),  32'd20_000_000);
    checkOutput("rst_level", 32'(level),      32'd1);
    checkScore("rst_score", 0, 0);

    // Screen sequence into PLAY at level 2.
    applyStimulus(K_ENTER);
    checkOutput("seq_choose", 32'(game_state), 32'd2);
    applyStimulus(K_2);
    checkOutput("seq_idle",  32'(game_state), 32'd0);
    checkOutput("seq_speed", 32'(mov_speed),  32'd12_000_000);
    checkOutput("seq_level", 32'(level),      32'd2);
    applyStimulus(K_ENTER);
    checkOutput("seq_play", 32'(game_state), 32'd3);
    checkOutput("seq_dir",  32'(dir_state),  32'd3);
    checkScore("seq_score", 0, 0);

    // Direction filter.
    applyStimulus(K_LEFT);
    checkOutput("dir_reverse", 32'(dir_state), 32'd3);
    applyStimulus(K_UP);
    checkOutput("dir_up", 32'(dir_state), 32'd0);
    applyStimulus(K_UP | K_RIGHT);
    checkOutput("dir_prio", 32'(dir_state), 32'd0);

    // Held target_ate counts once, then BCD carry.
    target_ate = 1'b1;
    tick(); tick(); tick();
    target_ate = 1'b0;
    tick();
    checkScore("held_once", 0, 1);
    feedEdges(9);
    checkScore("carry", 1, 0);

    // Win path.
    feedEdges(9);
    checkScore("score19", 1, 9);
    target_ate = 1'b1;
    tick();
    target_ate = 1'b0;
    checkScore("score20", 2, 0);
    checkOutput("win_not_yet", 32'(game_state), 32'd3);
    tick();
    checkOutput("win_entered", 32'(game_state), 32'd5);
    applyStimulus(K_ENTER);
    checkOutput("win_to_start", 32'(game_state), 32'd1);
    checkScore("win_held", 2, 0);

    // Lost beats a simultaneous score edge.
    applyStimulus(K_ENTER);
    applyStimulus(K_3);
    checkOutput("lvl3_level", 32'(level), 32'd3);
    applyStimulus(K_ENTER);
    checkScore("replay_clear", 0, 0);
    feedEdges(2);
    lost = 1'b1;
    target_ate = 1'b1;
    tick();
    lost = 1'b0;
    target_ate = 1'b0;
    checkOutput("lost_idle", 32'(game_state), 32'd0);
    checkScore("lost_score", 0, 2);

    // Pause freezes score and heading, and consumes target edges.
    applyStimulus(K_DOWN);
    checkOutput("start_down", 32'(dir_state), 32'd2);
    applyStimulus(K_PAUSE);
    checkOutput("paused", 32'(game_state), 32'd4);
    target_ate = 1'b1;
    setKeys(K_UP);
    tick();
    setKeys(0);
    checkScore("pause_score", 0, 0);
    checkOutput("pause_dir", 32'(dir_state), 32'd2);
    applyStimulus(K_PAUSE);
    checkOutput("unpaused", 32'(game_state), 32'd3);
    tick();
    target_ate = 1'b0;
    tick();
    checkScore("pause_edge_lost", 0, 0);

    // Reset mid-PLAY.
    applyStimulus(K_RIGHT);
    feedEdges(1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_state", 32'(game_state), 32'd1);
    checkOutput("midrst_dir",   32'(dir_state),  32'd3);
    checkOutput("midrst_speed", 32'(mov_speed),  32'd20_000_000);
    checkOutput("midrst_level", 32'(level),      32'd1);
    checkScore("midrst_score", 0, 0);

    // Randomized traffic checked by the model.
    for (int c = 0; c < 4000; c++) begin
      int k;
      k = 0;
      if ($urandom_range(0, 7) == 0) k |= K_UP;
      if ($urandom_range(0, 7) == 0) k |= K_LEFT;
      if ($urandom_range(0, 7) == 0) k |= K_DOWN;
      if ($urandom_range(0, 7) == 0) k |= K_RIGHT;
      if ($urandom_range(0, 5) == 0) k |= K_ENTER;
      if ($urandom_range(0, 29) == 0) k |= K_PAUSE;
      if ($urandom_range(0, 7) == 0) k |= K_1;
      if ($urandom_range(0, 7) == 0) k |= K_2;
      if ($urandom_range(0, 7) == 0) k |= K_3;
      setKeys(k);
      if ($urandom_range(0, 3) == 0) target_ate = ~target_ate;
      lost = ($urandom_range(0, 399) == 0);
      rst  = ($urandom_range(0, 999) == 0);
      tick();
    end
    setKeys(0);
    target_ate = 1'b0;
    lost = 1'b0;
    rst = 1'b0;
    tick();
    check_en = 1'b0;

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
